// File: rtl/ct_l2cache_data_seq_pkg.sv
`default_nettype none
// ============================================================================
// ct_l2cache_data_seq_pkg
//   Shared constants, state encoding and helpers for the L2 data sequencer.
//   Revision: 1.0
// ============================================================================
package ct_l2cache_data_seq_pkg;

   // L2 cache configuration: beat-level data index width for the 128K build
   localparam int c_L2_128K_DATA_INDEX_WIDTH = 10;

   localparam int c_BEATS       = 4;
   localparam int c_BEAT_NUM_W  = 2;
   localparam int c_BEAT_W      = 128;
   localparam int c_LINE_W      = c_BEATS * c_BEAT_W;
   localparam int c_BEAT_STRB_W = c_BEAT_W / 8;
   localparam int c_LINE_STRB_W = c_LINE_W / 8;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WR    = 3'd1,
      S_RD    = 3'd2,
      S_DRAIN = 3'd3,
      S_RSP   = 3'd4
   } state_t;

   // Byte strobes (active-high) to bit write enables (active-low)
   function automatic logic [c_BEAT_W-1:0] beat_wen(input logic [c_BEAT_STRB_W-1:0] strb);
      logic [c_BEAT_W-1:0] r;
      for (int n = 0; n < c_BEAT_W; n++) begin
         r[n] = ~strb[n/8];
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ct_l2cache_data_seq.sv
`default_nettype none
// ============================================================================
// ct_l2cache_data_seq
//   Splits 512-bit line reads/writes into four 128-bit data array beats.
//   Revision: 1.0
// ============================================================================
module ct_l2cache_data_seq
   import ct_l2cache_data_seq_pkg::*;
#(
   parameter int DATA_INDEX_WIDTH = c_L2_128K_DATA_INDEX_WIDTH,
   parameter int RD_LAT           = 1
)(
   input  logic                          forever_cpuclk,
   input  logic                          cpurst,
   input  logic                          req_vld,
   output logic                          req_rdy,
   input  logic                          req_wr,
   input  logic [DATA_INDEX_WIDTH-3:0]   req_idx,
   input  logic [c_LINE_W-1:0]           req_wdata,
   input  logic [c_LINE_STRB_W-1:0]      req_wstrb,
   output logic                          rsp_vld,
   input  logic                          rsp_rdy,
   output logic [c_LINE_W-1:0]           rsp_data,
   output logic                          wr_done,
   output logic                          data_cen,
   output logic                          data_gwen,
   output logic [c_BEAT_W-1:0]           data_wen,
   output logic [DATA_INDEX_WIDTH-1:0]   data_idx,
   output logic [c_BEAT_W-1:0]           data_din,
   input  logic [c_BEAT_W-1:0]           data_dout
);

   localparam int c_LINE_IDX_W = DATA_INDEX_WIDTH - c_BEAT_NUM_W;
   localparam logic [c_BEAT_NUM_W-1:0] c_LAST_BEAT = c_BEAT_NUM_W'(c_BEATS - 1);

   state_t                                   r_state;
   logic [c_BEAT_NUM_W-1:0]                  r_beat;
   logic [c_LINE_IDX_W-1:0]                  r_idx;
   logic [c_LINE_W-1:0]                      r_wdata;
   logic [c_LINE_STRB_W-1:0]                 r_wstrb;
   logic [RD_LAT-1:0]                        r_pipe_vld;
   logic [RD_LAT-1:0][c_BEAT_NUM_W-1:0]      r_pipe_beat;

   logic                      w_idle;
   logic                      w_accept;
   logic                      w_in_beats;
   logic                      w_issue;
   logic                      w_issue_wr;
   logic [c_BEAT_NUM_W-1:0]   w_beat_nxt;
   logic [c_LINE_IDX_W-1:0]   w_src_idx;
   logic [c_LINE_W-1:0]       w_src_wdata;
   logic [c_LINE_STRB_W-1:0]  w_src_wstrb;
   logic [c_BEAT_STRB_W-1:0]  w_beat_strb;
   logic [c_BEAT_W-1:0]       w_beat_din;
   logic                      w_cap_vld;
   logic [c_BEAT_NUM_W-1:0]   w_cap_beat;

   assign w_idle     = (r_state == S_IDLE);
   assign w_accept   = w_idle & req_vld;
   assign w_in_beats = (r_state == S_WR) | (r_state == S_RD);
   assign w_issue    = w_accept | (w_in_beats & (r_beat != c_LAST_BEAT));
   assign req_rdy    = w_idle;

   // Beat 0 is launched straight from the request so it lands in the cycle after the handshake
   assign w_issue_wr  = w_idle ? req_wr    : (r_state == S_WR);
   assign w_beat_nxt  = w_idle ? '0        : r_beat + c_BEAT_NUM_W'(1);
   assign w_src_idx   = w_idle ? req_idx   : r_idx;
   assign w_src_wdata = w_idle ? req_wdata : r_wdata;
   assign w_src_wstrb = w_idle ? req_wstrb : r_wstrb;
   assign w_beat_din  = w_src_wdata[w_beat_nxt*c_BEAT_W +: c_BEAT_W];
   assign w_beat_strb = w_src_wstrb[w_beat_nxt*c_BEAT_STRB_W +: c_BEAT_STRB_W];

   assign w_cap_vld  = r_pipe_vld[RD_LAT-1];
   assign w_cap_beat = r_pipe_beat[RD_LAT-1];

   always_ff @(posedge forever_cpuclk or posedge cpurst) begin
      if (cpurst) begin
         r_state     <= S_IDLE;
         r_beat      <= '0;
         r_idx       <= '0;
         r_wdata     <= '0;
         r_wstrb     <= '0;
         r_pipe_vld  <= '0;
         r_pipe_beat <= '0;
         data_cen    <= 1'b1;
         data_gwen   <= 1'b1;
         data_wen    <= '1;
         data_idx    <= '0;
         data_din    <= '0;
         rsp_vld     <= 1'b0;
         rsp_data    <= '0;
         wr_done     <= 1'b0;
      end else begin
         wr_done   <= 1'b0;
         data_cen  <= 1'b1;
         data_gwen <= 1'b1;
         data_wen  <= '1;

         if (w_issue) begin
            r_beat   <= w_beat_nxt;
            data_idx <= {w_src_idx, w_beat_nxt};
            if (w_issue_wr) begin
               // A fully masked beat still burns its slot but leaves the array idle
               data_cen  <= ~|w_beat_strb;
               data_gwen <= 1'b0;
               data_wen  <= beat_wen(w_beat_strb);
               data_din  <= w_beat_din;
            end else begin
               data_cen  <= 1'b0;
            end
         end

         r_pipe_vld[0]  <= (r_state == S_RD);
         r_pipe_beat[0] <= r_beat;
         for (int i = 1; i < RD_LAT; i++) begin
            r_pipe_vld[i]  <= r_pipe_vld[i-1];
            r_pipe_beat[i] <= r_pipe_beat[i-1];
         end

         if (w_cap_vld) begin
            rsp_data[w_cap_beat*c_BEAT_W +: c_BEAT_W] <= data_dout;
         end

         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_state <= req_wr ? S_WR : S_RD;
                  r_idx   <= req_idx;
                  r_wdata <= req_wdata;
                  r_wstrb <= req_wstrb;
               end
            end
            S_WR: begin
               if (r_beat == c_LAST_BEAT) begin
                  r_state <= S_IDLE;
                  wr_done <= 1'b1;
               end
            end
            S_RD: begin
               if (r_beat == c_LAST_BEAT) begin
                  r_state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (w_cap_vld && (w_cap_beat == c_LAST_BEAT)) begin
                  r_state <= S_RSP;
                  rsp_vld <= 1'b1;
               end
            end
            S_RSP: begin
               if (rsp_rdy) begin
                  r_state <= S_IDLE;
                  rsp_vld <= 1'b0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ct_l2cache_data_seq.sv
`default_nettype none
// ============================================================================
// tb_ct_l2cache_data_seq
//   Two sequencers (RD_LAT=1 and 2) on behavioural arrays; scoreboarded checks.
//   Revision: 1.0
// ============================================================================
module tb_ct_l2cache_data_seq;

   typedef struct {
      int          inst;
      int          cyc;
      logic [9:0]  idx;
      logic        cen;
      logic        gwen;
      logic [127:0] wen;
      logic [127:0] din;
      bit          chk_din;
   } exp_beat_t;

   typedef struct {
      int inst;
      int cyc;
   } exp_done_t;

   typedef struct {
      int           inst;
      int           cyc;
      logic [511:0] data;
   } exp_rsp_t;

   typedef struct {
      bit           wr;
      logic [7:0]   idx;
      logic [511:0] wdata;
      logic [63:0]  wstrb;
      logic [3:0]   mask;
      int           lat;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic         rst       [2];
   logic         req_vld   [2];
   logic         req_rdy   [2];
   logic         req_wr    [2];
   logic [7:0]   req_idx   [2];
   logic [511:0] req_wdata [2];
   logic [63:0]  req_wstrb [2];
   logic         rsp_vld   [2];
   logic         rsp_rdy   [2];
   logic [511:0] rsp_data  [2];
   logic         wr_done   [2];
   logic         data_cen  [2];
   logic         data_gwen [2];
   logic [127:0] data_wen  [2];
   logic [9:0]   data_idx  [2];
   logic [127:0] data_din  [2];
   logic [127:0] data_dout [2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      logic [127:0] mem [1024];
      logic [127:0] q1;
      logic [127:0] q2;

      initial begin
         for (int a = 0; a < 1024; a++) mem[a] = '0;
         q1 = '0;
         q2 = '0;
      end

      always @(posedge clk) begin
         if (!data_cen[g]) begin
            if (!data_gwen[g])
               mem[data_idx[g]] <= (mem[data_idx[g]] & data_wen[g]) | (data_din[g] & ~data_wen[g]);
            else
               q1 <= mem[data_idx[g]];
         end
         q2 <= q1;
      end

      assign data_dout[g] = (g == 0) ? q1 : q2;

      ct_l2cache_data_seq #(
         .DATA_INDEX_WIDTH (10),
         .RD_LAT           (g + 1)
      ) u_dut (
         .forever_cpuclk (clk),
         .cpurst         (rst[g]),
         .req_vld        (req_vld[g]),
         .req_rdy        (req_rdy[g]),
         .req_wr         (req_wr[g]),
         .req_idx        (req_idx[g]),
         .req_wdata      (req_wdata[g]),
         .req_wstrb      (req_wstrb[g]),
         .rsp_vld        (rsp_vld[g]),
         .rsp_rdy        (rsp_rdy[g]),
         .rsp_data       (rsp_data[g]),
         .wr_done        (wr_done[g]),
         .data_cen       (data_cen[g]),
         .data_gwen      (data_gwen[g]),
         .data_wen       (data_wen[g]),
         .data_idx       (data_idx[g]),
         .data_din       (data_din[g]),
         .data_dout      (data_dout[g])
      );
   end

   int n_checks = 0;
   int n_fail   = 0;

   exp_beat_t beat_q [$];
   exp_done_t done_q [$];
   exp_rsp_t  rsp_q  [$];

   logic [511:0] ref_line [2][256];

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] exp_wen(input logic [15:0] s);
      logic [127:0] r;
      for (int n = 0; n < 128; n++) r[n] = ~s[n/8];
      return r;
   endfunction

   task automatic push_expect(input int i, input bit wr, input logic [7:0] idx,
                              input logic [511:0] wdata, input logic [63:0] wstrb,
                              input logic [3:0] mask, input int lat, input int tc);
      exp_beat_t b;
      exp_done_t d;
      exp_rsp_t  r;
      for (int k = 0; k < 4; k++) begin
         logic [1:0] kk;
         kk        = k[1:0];
         b.inst    = i;
         b.cyc     = tc + 1 + k;
         b.idx     = {idx, kk};
         b.cen     = ~mask[k];
         b.gwen    = ~wr;
         b.wen     = wr ? exp_wen(wstrb[16*k +: 16]) : '1;
         b.din     = wdata[128*k +: 128];
         b.chk_din = wr;
         beat_q.push_back(b);
      end
      if (wr) begin
         for (int by = 0; by < 64; by++)
            if (wstrb[by]) ref_line[i][idx][8*by +: 8] = wdata[8*by +: 8];
         d.inst = i;
         d.cyc  = tc + lat;
         done_q.push_back(d);
      end else begin
         r.inst = i;
         r.cyc  = tc + lat;
         r.data = ref_line[i][idx];
         rsp_q.push_back(r);
      end
   endtask

   task automatic do_req(input int i, input bit wr, input logic [7:0] idx,
                         input logic [511:0] wdata, input logic [63:0] wstrb,
                         input logic [3:0] mask, input int lat, output int tc);
      int n;
      @(negedge clk);
      req_vld[i]   = 1'b1;
      req_wr[i]    = wr;
      req_idx[i]   = idx;
      req_wdata[i] = wdata;
      req_wstrb[i] = wstrb;
      n = 0;
      while (!req_rdy[i] && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!req_rdy[i]) check("req_accept_timeout", 0, 1);
      tc = cyc;
      push_expect(i, wr, idx, wdata, wstrb, mask, lat, tc);
      @(negedge clk);
      req_vld[i] = 1'b0;
   endtask

   task automatic wait_done(input int i);
      int n;
      n = 0;
      while ((beat_q.size() != 0 || done_q.size() != 0 || rsp_q.size() != 0 || !req_rdy[i]) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) check("completion_timeout", 0, 1);
   endtask

   logic      prev_vld [2] = '{1'b0, 1'b0};
   exp_beat_t mb;
   exp_done_t md;
   exp_rsp_t  mr;

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (!data_cen[i] || !data_gwen[i]) begin
            if (beat_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_beat: inst %0d idx %0d at cycle %0d, none expected", i, data_idx[i], cyc);
            end else begin
               mb = beat_q.pop_front();
               check("beat_inst", i, mb.inst);
               check("beat_cycle", cyc, mb.cyc);
               check("beat_idx", data_idx[i], mb.idx);
               check("beat_cen", data_cen[i], mb.cen);
               check("beat_gwen", data_gwen[i], mb.gwen);
               check("beat_wen", data_wen[i], mb.wen);
               if (mb.chk_din) check("beat_din", data_din[i], mb.din);
            end
         end
         if (wr_done[i]) begin
            if (done_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_wr_done: inst %0d at cycle %0d", i, cyc);
            end else begin
               md = done_q.pop_front();
               check("wr_done_inst", i, md.inst);
               check("wr_done_cycle", cyc, md.cyc);
               check("req_rdy_at_wr_done", req_rdy[i], 1);
            end
         end
         if (rsp_vld[i] && !prev_vld[i]) begin
            if (rsp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_rsp_vld: inst %0d at cycle %0d", i, cyc);
            end else begin
               mr = rsp_q.pop_front();
               check("rsp_inst", i, mr.inst);
               check("rsp_cycle", cyc, mr.cyc);
               check("rsp_data", rsp_data[i], mr.data);
            end
         end
         prev_vld[i] = rsp_vld[i];
      end
   end

   vec_t         tbl [8];
   logic [511:0] line0, line1, line2, line7;
   logic [3:0]   nib;
   int           tc, n;
   logic [511:0] held;

   initial begin
      for (int i = 0; i < 2; i++) begin
         rst[i] = 1'b1; req_vld[i] = 1'b0; req_wr[i] = 1'b0; req_idx[i] = '0;
         req_wdata[i] = '0; req_wstrb[i] = '0; rsp_rdy[i] = 1'b1;
         for (int a = 0; a < 256; a++) ref_line[i][a] = '0;
      end
      for (int k = 0; k < 4; k++) begin
         nib = k[3:0];
         line0[128*k +: 128] = {32{nib}};
      end
      line1 = {16{32'hDEAD_BEEF}} ^ {8{64'h0123_4567_89AB_CDEF}};
      line2 = {8{64'hFEDC_BA98_7654_3210}};
      line7 = {16{32'h5A5A_C3C3}};

      tbl[0] = '{1'b1, 8'd5,   line0, '1,                     4'b1111, 5};
      tbl[1] = '{1'b1, 8'd9,   line1, 64'h0000_FFFF_0000_0001, 4'b0101, 5};
      tbl[2] = '{1'b0, 8'd5,   '0,    '0,                     4'b1111, 6};
      tbl[3] = '{1'b0, 8'd9,   '0,    '0,                     4'b1111, 6};
      tbl[4] = '{1'b1, 8'd255, line2, '1,                     4'b1111, 5};
      tbl[5] = '{1'b0, 8'd255, '0,    '0,                     4'b1111, 6};
      tbl[6] = '{1'b1, 8'd3,   line2, '0,                     4'b0000, 5};
      tbl[7] = '{1'b0, 8'd3,   '0,    '0,                     4'b1111, 6};

      #1;
      check("rst_cen", data_cen[0], 1);
      check("rst_gwen", data_gwen[0], 1);
      check("rst_wen", data_wen[0], {128{1'b1}});
      check("rst_idx", data_idx[0], 0);
      check("rst_din", data_din[0], 0);
      check("rst_rsp_vld", rsp_vld[0], 0);
      check("rst_rsp_data", rsp_data[0], 0);
      check("rst_wr_done", wr_done[0], 0);
      check("rst_req_rdy", req_rdy[0], 1);
      repeat (3) @(negedge clk);
      rst[0] = 1'b0;
      rst[1] = 1'b0;

      for (int v = 0; v < 8; v++) begin
         do_req(0, tbl[v].wr, tbl[v].idx, tbl[v].wdata, tbl[v].wstrb, tbl[v].mask, tbl[v].lat, tc);
         wait_done(0);
      end

      // Response stall: held data, no acceptance, no array traffic
      rsp_rdy[0] = 1'b0;
      do_req(0, 1'b0, 8'd5, '0, '0, 4'b1111, 6, tc);
      n = 0;
      while (!rsp_vld[0] && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("stall_rsp_seen", rsp_vld[0], 1);
      held = ref_line[0][5];
      for (int s = 0; s < 10; s++) begin
         @(negedge clk);
         check("stall_rsp_vld", rsp_vld[0], 1);
         check("stall_rsp_data", rsp_data[0], held);
         check("stall_req_rdy", req_rdy[0], 0);
      end
      rsp_rdy[0] = 1'b1;
      @(negedge clk);
      check("release_rsp_vld", rsp_vld[0], 0);
      check("release_req_rdy", req_rdy[0], 1);
      wait_done(0);

      // Back-to-back write then read with req_vld held high
      @(negedge clk);
      req_vld[0] = 1'b1; req_wr[0] = 1'b1; req_idx[0] = 8'd7;
      req_wdata[0] = line7; req_wstrb[0] = '1;
      n = 0;
      while (!req_rdy[0] && n < 50) begin
         @(negedge clk);
         n++;
      end
      tc = cyc;
      push_expect(0, 1'b1, 8'd7, line7, '1, 4'b1111, 5, tc);
      @(negedge clk);
      req_wr[0] = 1'b0;
      n = 0;
      while (!req_rdy[0] && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("b2b_second_accept_cycle", cyc, tc + 5);
      tc = cyc;
      push_expect(0, 1'b0, 8'd7, '0, '0, 4'b1111, 6, tc);
      @(negedge clk);
      req_vld[0] = 1'b0;
      wait_done(0);

      // Reset while read beat 2 is on the array
      do_req(0, 1'b0, 8'd9, '0, '0, 4'b1111, 6, tc);
      n = 0;
      while (cyc != tc + 3 && n < 20) begin
         @(negedge clk);
         n++;
      end
      #2 rst[0] = 1'b1;
      #1;
      check("midrst_cen", data_cen[0], 1);
      check("midrst_gwen", data_gwen[0], 1);
      check("midrst_wen", data_wen[0], {128{1'b1}});
      check("midrst_idx", data_idx[0], 0);
      check("midrst_din", data_din[0], 0);
      check("midrst_rsp_vld", rsp_vld[0], 0);
      check("midrst_req_rdy", req_rdy[0], 1);
      check("midrst_beats_left", beat_q.size(), 1);
      if (beat_q.size() > 0) void'(beat_q.pop_back());
      if (rsp_q.size() > 0) void'(rsp_q.pop_back());
      @(negedge clk);
      #2 rst[0] = 1'b0;
      repeat (12) @(negedge clk);
      check("post_rst_rsp_vld", rsp_vld[0], 0);
      do_req(0, 1'b0, 8'd9, '0, '0, 4'b1111, 6, tc);
      wait_done(0);

      // RD_LAT=2 instance
      do_req(1, 1'b1, 8'd5, line0, '1, 4'b1111, 5, tc);
      wait_done(1);
      do_req(1, 1'b0, 8'd5, '0, '0, 4'b1111, 7, tc);
      wait_done(1);

      repeat (3) @(negedge clk);
      check("beat_q_empty", beat_q.size(), 0);
      check("done_q_empty", done_q.size(), 0);
      check("rsp_q_empty", rsp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
